// File: rtl/rvh_l1d_mshr_sched.sv
// L1D miss-status holding register scheduler: merges or allocates per-requester misses,
// issues one WAIT_ISSUE entry at a time to L2, and frees entries on refill completion.

module rvh_l1d_mshr_entry #(
  parameter int LINE_ADDR_W = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc,
  input  logic [LINE_ADDR_W-1:0] alloc_addr,
  input  logic                   issue_hs,
  input  logic                   refill,
  output logic                   is_free,
  output logic                   is_wait_issue,
  output logic [LINE_ADDR_W-1:0] line_addr
);
  typedef enum logic [1:0] {
    FREE        = 2'd0,
    WAIT_ISSUE  = 2'd1,
    WAIT_REFILL = 2'd2
  } state_e;

  state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  // refill is only honoured while waiting for it; stray completions are dropped
  always_comb begin
    state_nxt = state;
    case (state)
      FREE:        if (alloc)    state_nxt = WAIT_ISSUE;
      WAIT_ISSUE:  if (issue_hs) state_nxt = WAIT_REFILL;
      WAIT_REFILL: if (refill)   state_nxt = FREE;
      default:                   state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        line_addr <= '0;
    else if (alloc) line_addr <= alloc_addr;
  end

  assign is_free       = (state == FREE);
  assign is_wait_issue = (state == WAIT_ISSUE);
endmodule

module rvh_l1d_mshr_sched #(
  parameter int N_MSHR      = 4,
  parameter int N_REQ       = 2,
  parameter int LINE_ADDR_W = 34,
  parameter int ID_W        = $clog2(N_MSHR)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_vld_i,
  input  logic [N_REQ*LINE_ADDR_W-1:0] req_line_addr_i,
  output logic [N_REQ-1:0]             req_rdy_o,
  output logic [N_REQ-1:0]             req_merge_o,
  output logic [N_REQ*ID_W-1:0]        req_mshr_id_o,
  output logic                         l2_req_vld_o,
  input  logic                         l2_req_rdy_i,
  output logic [ID_W-1:0]              l2_req_mshr_id_o,
  output logic [LINE_ADDR_W-1:0]       l2_req_line_addr_o,
  input  logic                         refill_done_vld_i,
  input  logic [ID_W-1:0]              refill_done_mshr_id_i,
  output logic [N_MSHR-1:0]            mshr_valid_o,
  output logic [ID_W:0]                free_mshr_num_o,
  output logic                         has_free_mshr_o
);
  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } issue_lock_t;

  logic [N_REQ-1:0][LINE_ADDR_W-1:0]  req_addr;
  logic [N_MSHR-1:0][LINE_ADDR_W-1:0] ent_addr;
  logic [N_MSHR-1:0]                  ent_free, ent_wait_issue;
  logic [N_MSHR-1:0]                  ent_alloc, ent_issue_hs, ent_refill;

  logic [N_REQ-1:0]                   merge_hit, alloc_cand;
  logic [N_REQ-1:0][ID_W-1:0]         merge_id;
  logic                               free_any, win_any, grant;
  logic [ID_W-1:0]                    free_id;
  logic [RR_W-1:0]                    rr_ptr, win;
  int                                 best;

  logic                               iss_any, l2_hs;
  logic [ID_W-1:0]                    iss_id;
  issue_lock_t                        lock;

  for (genvar k = 0; k < N_REQ; k++) begin : g_req
    assign req_addr[k] = req_line_addr_i[k*LINE_ADDR_W +: LINE_ADDR_W];
    assign alloc_cand[k] = req_vld_i[k] && !merge_hit[k];
    assign req_rdy_o[k] = !rst && (merge_hit[k] || (grant && win == RR_W'(k)));
    assign req_merge_o[k] = merge_hit[k];
    assign req_mshr_id_o[k*ID_W +: ID_W] = merge_hit[k] ? merge_id[k] : free_id;
  end

  for (genvar e = 0; e < N_MSHR; e++) begin : g_ent
    assign ent_alloc[e]    = grant && (free_id == ID_W'(e));
    assign ent_issue_hs[e] = l2_hs && (l2_req_mshr_id_o == ID_W'(e));
    assign ent_refill[e]   = refill_done_vld_i && (refill_done_mshr_id_i == ID_W'(e));

    rvh_l1d_mshr_entry #(.LINE_ADDR_W(LINE_ADDR_W)) u_ent (
      .clk           (clk),
      .rst           (rst),
      .alloc         (ent_alloc[e]),
      .alloc_addr    (req_addr[win]),
      .issue_hs      (ent_issue_hs[e]),
      .refill        (ent_refill[e]),
      .is_free       (ent_free[e]),
      .is_wait_issue (ent_wait_issue[e]),
      .line_addr     (ent_addr[e])
    );
  end

  // an entry completing this cycle is about to drop its line, so it must not absorb new misses
  always_comb begin
    merge_hit = '0;
    merge_id  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int e = N_MSHR-1; e >= 0; e--) begin
        if (req_vld_i[k] && !ent_free[e] && !ent_refill[e] && ent_addr[e] == req_addr[k]) begin
          merge_hit[k] = 1'b1;
          merge_id[k]  = ID_W'(e);
        end
      end
    end
  end

  always_comb begin
    free_any = 1'b0;
    free_id  = '0;
    for (int e = N_MSHR-1; e >= 0; e--) begin
      if (ent_free[e]) begin
        free_any = 1'b1;
        free_id  = ID_W'(e);
      end
    end
  end

  // round-robin: nearest candidate at or after rr_ptr wins
  always_comb begin
    win_any = 1'b0;
    win     = '0;
    best    = N_REQ;
    for (int k = 0; k < N_REQ; k++) begin
      if (alloc_cand[k] && ((k + N_REQ - int'(rr_ptr)) % N_REQ) < best) begin
        best    = (k + N_REQ - int'(rr_ptr)) % N_REQ;
        win     = RR_W'(k);
        win_any = 1'b1;
      end
    end
  end

  assign grant = win_any && free_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_ptr <= '0;
    else if (grant) rr_ptr <= (int'(win) == N_REQ-1) ? '0 : win + RR_W'(1);
  end

  always_comb begin
    iss_any = 1'b0;
    iss_id  = '0;
    for (int e = N_MSHR-1; e >= 0; e--) begin
      if (ent_wait_issue[e]) begin
        iss_any = 1'b1;
        iss_id  = ID_W'(e);
      end
    end
  end

  // once offered, the L2 request is frozen until accepted
  assign l2_req_vld_o       = !rst && (lock.vld || iss_any);
  assign l2_req_mshr_id_o   = lock.vld ? lock.id : iss_id;
  assign l2_req_line_addr_o = ent_addr[l2_req_mshr_id_o];
  assign l2_hs              = l2_req_vld_o && l2_req_rdy_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock <= '0;
    end else if (l2_hs) begin
      lock.vld <= 1'b0;
    end else if (l2_req_vld_o) begin
      lock.vld <= 1'b1;
      lock.id  <= l2_req_mshr_id_o;
    end
  end

  always_comb begin
    free_mshr_num_o = '0;
    for (int e = 0; e < N_MSHR; e++)
      free_mshr_num_o = free_mshr_num_o + (ID_W+1)'(ent_free[e]);
  end

  assign mshr_valid_o    = ~ent_free;
  assign has_free_mshr_o = free_any;
endmodule
